// File: rtl/adder_pkg.sv
// Shared add/subtract mode encoding and parameter legality helper.
// Reused by the pipelined adder and the future ALU.
package adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic bit params_ok(int w, int stages);
    return (w >= 1) && (stages >= 1) &&
           (stages <= w) && ((w % stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_adder_array_if.sv
// Valid/ready bundle for the pipelined adder: operation in, result out.
// master drives operations and accepts results; slave is the adder.
interface pipelined_adder_array_if #(
  parameter int W = 8
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/full_adder_cell.sv
// One-bit full adder; the leaf cell of the pipelined adder array.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_adder_array.sv
// W-bit add/subtract with the carry chain cut into STAGES registered slices.
// Slice k adds bits [k*C +: C]; operands and partial sums travel alongside.
module pipelined_adder_array
  import adder_pkg::*;
#(
  parameter int W      = 8,
  parameter int STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pipelined_adder_array_if.slave  bus
);

  localparam int C = (STAGES >= 1) ? (W / STAGES) : 1;
  localparam int L = STAGES - 1;
  localparam logic [W-1:0] SLM = {W{1'b1}} >> (W - C);

  if (!params_ok(W, STAGES)) begin : g_bad_params
    $error("pipelined_adder_array: illegal W/STAGES combination");
  end

  logic               adv;
  logic [W-1:0]       op_a [STAGES];
  logic [W-1:0]       op_b [STAGES];
  logic [W-1:0]       op_s [STAGES];
  logic               op_c [STAGES];
  logic               op_v [STAGES];
  logic [W-1:0]       fa_s;
  logic [STAGES-1:0]  sl_ci;
  logic [STAGES-1:0]  sl_co;

  logic               v_d [STAGES];
  logic               v_q [STAGES];
  logic               c_d [STAGES];
  logic               c_q [STAGES];
  logic               o_d [STAGES];
  logic               o_q [STAGES];
  logic [W-1:0]       a_d [STAGES];
  logic [W-1:0]       a_q [STAGES];
  logic [W-1:0]       b_d [STAGES];
  logic [W-1:0]       b_q [STAGES];
  logic [W-1:0]       s_d [STAGES];
  logic [W-1:0]       s_q [STAGES];

  assign adv           = !v_q[L] || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = v_q[L];
  assign bus.sum       = s_q[L];
  assign bus.cout      = c_q[L];
  assign bus.ovf       = o_q[L];

  always_comb begin : p_ops
    op_v[0] = bus.in_valid;
    op_a[0] = bus.a;
    op_b[0] = bus.b ^ {W{bus.sub == OP_SUB}};
    op_s[0] = '0;
    op_c[0] = bus.sub;
    for (int k = 1; k < STAGES; k++) begin
      op_v[k] = v_q[k-1];
      op_a[k] = a_q[k-1];
      op_b[k] = b_q[k-1];
      op_s[k] = s_q[k-1];
      op_c[k] = c_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    for (genvar j = 0; j < C; j++) begin : g_bit
      localparam int I = k * C + j;
      logic ci;
      logic co;
      if (j == 0) begin : g_c0
        assign ci = op_c[k];
      end else begin : g_cn
        assign ci = g_bit[j-1].co;
      end
      full_adder_cell u_fa (
        .a    (op_a[k][I]),
        .b    (op_b[k][I]),
        .cin  (ci),
        .sum  (fa_s[I]),
        .cout (co)
      );
    end
    // carry into the slice MSB feeds the signed-overflow flag
    assign sl_ci[k] = g_bit[C-1].ci;
    assign sl_co[k] = g_bit[C-1].co;
  end

  always_comb begin : p_next
    for (int k = 0; k < STAGES; k++) begin
      v_d[k] = v_q[k];
      a_d[k] = a_q[k];
      b_d[k] = b_q[k];
      s_d[k] = s_q[k];
      c_d[k] = c_q[k];
      o_d[k] = o_q[k];
      if (adv) begin
        v_d[k] = op_v[k];
        a_d[k] = op_a[k];
        b_d[k] = op_b[k];
        s_d[k] = (op_s[k] & ~(SLM << (k * C))) |
                 (fa_s & (SLM << (k * C)));
        c_d[k] = sl_co[k];
        o_d[k] = sl_ci[k] ^ sl_co[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        o_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_d[k];
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
        o_q[k] <= o_d[k];
      end
    end
  end

endmodule
